// File: rtl/debug_step_ctrl.sv
// Run/step/breakpoint sequencer that produces the core clock-enable and a gated interrupt request.
// Optional feature macro: DEBUG_BREAKPOINT_EN (PC breakpoint and BREAK state).
module debug_step_ctrl #(
  parameter int unsigned STEP_CYCLES = 1,
  parameter int unsigned CNT_WIDTH   = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 debug_en,
  input  logic                 step_btn,
  input  logic                 int_sw,
  input  logic [31:0]          pc,
  input  logic [31:0]          bp_addr,
  input  logic                 bp_valid,
  output logic                 cpu_en,
  output logic                 int_req,
  output logic                 halted,
  output logic [1:0]           state,
  output logic [CNT_WIDTH-1:0] step_count
);

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_HALT  = 2'd1,
    S_STEP  = 2'd2,
    S_BREAK = 2'd3
  } state_e;

  localparam logic [7:0] STEP_LOAD = 8'(STEP_CYCLES - 1);

  state_e               state_q, state_d;
  logic [7:0]           step_cnt_q, step_cnt_d;
  logic [CNT_WIDTH-1:0] step_count_q, step_count_d;
  logic                 step_s1_q, step_s2_q, step_h_q;
  logic                 int_s1_q, int_s2_q, int_h_q;
  logic                 int_pend_q, int_pend_d;
  logic                 step_edge, int_edge;
  logic                 bp_hit;

  assign step_edge = step_s2_q & ~step_h_q;
  assign int_edge  = int_s2_q & ~int_h_q;

`ifdef DEBUG_BREAKPOINT_EN
  logic bp_skip_q, bp_skip_d;

  assign bp_hit = (state_q == S_RUN) & bp_valid & (pc == bp_addr) & ~bp_skip_q;

  // Suppress the breakpoint for the first enabled RUN cycle so a resume can leave bp_addr.
  always_comb begin
    bp_skip_d = bp_skip_q;
    if ((state_q != S_RUN) && (state_d == S_RUN)) begin
      bp_skip_d = 1'b1;
    end else if ((state_q == S_RUN) && cpu_en) begin
      bp_skip_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bp_skip_q <= 1'b0;
    end else begin
      bp_skip_q <= bp_skip_d;
    end
  end
`else
  logic unused_bp;

  assign bp_hit    = 1'b0;
  assign unused_bp = ^{pc, bp_addr, bp_valid};
`endif

  // State register plus synchronisers and counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_HALT;
      step_cnt_q   <= 8'd0;
      step_count_q <= '0;
      step_s1_q    <= 1'b0;
      step_s2_q    <= 1'b0;
      step_h_q     <= 1'b0;
      int_s1_q     <= 1'b0;
      int_s2_q     <= 1'b0;
      int_h_q      <= 1'b0;
      int_pend_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      step_cnt_q   <= step_cnt_d;
      step_count_q <= step_count_d;
      step_s1_q    <= step_btn;
      step_s2_q    <= step_s1_q;
      step_h_q     <= step_s2_q;
      int_s1_q     <= int_sw;
      int_s2_q     <= int_s1_q;
      int_h_q      <= int_s2_q;
      int_pend_q   <= int_pend_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    step_cnt_d = step_cnt_q;
    case (state_q)
      S_RUN: begin
        if (debug_en) begin
          state_d = S_HALT;
        end else if (bp_hit) begin
          state_d = S_BREAK;
        end
      end
      S_HALT: begin
        if (!debug_en) begin
          state_d = S_RUN;
        end else if (step_edge) begin
          state_d    = S_STEP;
          step_cnt_d = STEP_LOAD;
        end
      end
      S_STEP: begin
        if (step_cnt_q == 8'd0) begin
          state_d = debug_en ? S_HALT : S_RUN;
        end else begin
          step_cnt_d = step_cnt_q - 8'd1;
        end
      end
      S_BREAK: begin
        if (step_edge) begin
          state_d    = S_STEP;
          step_cnt_d = STEP_LOAD;
        end else if (debug_en) begin
          state_d = S_HALT;
        end
      end
      default: state_d = S_HALT;
    endcase
  end

  always_comb begin
    cpu_en = 1'b0;
    halted = 1'b0;
    state  = state_q;
    case (state_q)
      S_RUN:   cpu_en = ~bp_hit;
      S_STEP:  cpu_en = 1'b1;
      S_HALT:  halted = 1'b1;
      S_BREAK: halted = 1'b1;
      default: halted = 1'b1;
    endcase
  end

  // A pending request survives halts; a fresh edge in the delivery cycle keeps it pending.
  assign int_req      = int_pend_q & cpu_en;
  assign int_pend_d   = int_edge | (int_pend_q & ~cpu_en);
  assign step_count_d = cpu_en ? step_count_q + CNT_WIDTH'(1) : step_count_q;
  assign step_count   = step_count_q;

endmodule

// File: tb/tb_debug_step_ctrl.sv
// Directed self-checking bench for debug_step_ctrl with STEP_CYCLES=3.
// Breakpoint scenarios run when DEBUG_BREAKPOINT_EN is defined; otherwise the bench checks pc/bp are ignored.
module tb_debug_step_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        debug_en = 1'b0;
  logic        step_btn = 1'b0;
  logic        int_sw = 1'b0;
  logic [31:0] pc = 32'd0;
  logic [31:0] bp_addr = 32'd0;
  logic        bp_valid = 1'b0;
  logic        cpu_en;
  logic        int_req;
  logic        halted;
  logic [1:0]  state;
  logic [31:0] step_count;

  logic        core_run = 1'b0;
  int          checks = 0;
  int          errors = 0;

  debug_step_ctrl #(.STEP_CYCLES(3), .CNT_WIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .debug_en   (debug_en),
    .step_btn   (step_btn),
    .int_sw     (int_sw),
    .pc         (pc),
    .bp_addr    (bp_addr),
    .bp_valid   (bp_valid),
    .cpu_en     (cpu_en),
    .int_req    (int_req),
    .halted     (halted),
    .state      (state),
    .step_count (step_count)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One clock; the stand-in core advances pc by 4 for each enabled cycle.
  task automatic tick;
    logic en_prev;
    en_prev = cpu_en;
    @(posedge clk);
    #1;
    if (core_run && en_prev) pc = pc + 32'd4;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    debug_en = 1'b0;
    tick();
    tick();
    checks++; if (cpu_en !== 1'b0) begin errors++; $display("FAIL reset_cpu_en got %b want 0", cpu_en); end
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL reset_state got %0d want 1", state); end
    checks++; if (halted !== 1'b1) begin errors++; $display("FAIL reset_halted got %b want 1", halted); end
    checks++; if (int_req !== 1'b0) begin errors++; $display("FAIL reset_int_req got %b want 0", int_req); end
    checks++; if (step_count !== 32'd0) begin errors++; $display("FAIL reset_count got %0d want 0", step_count); end
  endtask

  task automatic test_run;
    rst = 1'b0;
    tick();
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL run_state got %0d want 0", state); end
    checks++; if (cpu_en !== 1'b1) begin errors++; $display("FAIL run_cpu_en got %b want 1", cpu_en); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL run_halted got %b want 0", halted); end
    repeat (10) tick();
    checks++; if (step_count !== 32'd10) begin errors++; $display("FAIL run_count got %0d want 10", step_count); end
    debug_en = 1'b1;
    tick();
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL run_to_halt got %0d want 1", state); end
    checks++; if (step_count !== 32'd11) begin errors++; $display("FAIL run_to_halt_count got %0d want 11", step_count); end
  endtask

  task automatic test_step;
    step_btn = 1'b1;
    tick();
    step_btn = 1'b0;
    tick();
    checks++; if (cpu_en !== 1'b0) begin errors++; $display("FAIL step_early got %b want 0", cpu_en); end
    tick();
    checks++; if (cpu_en !== 1'b1 || state !== 2'd2) begin errors++; $display("FAIL step_c1 got en=%b st=%0d want en=1 st=2", cpu_en, state); end
    step_btn = 1'b1;
    tick();
    checks++; if (cpu_en !== 1'b1) begin errors++; $display("FAIL step_c2 got %b want 1", cpu_en); end
    step_btn = 1'b0;
    tick();
    checks++; if (cpu_en !== 1'b1) begin errors++; $display("FAIL step_c3 got %b want 1", cpu_en); end
    tick();
    checks++; if (cpu_en !== 1'b0 || state !== 2'd1) begin errors++; $display("FAIL step_end got en=%b st=%0d want en=0 st=1", cpu_en, state); end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (cpu_en !== 1'b0) begin errors++; $display("FAIL step_no_requeue cyc %0d got %b want 0", i, cpu_en); end
    end
    checks++; if (step_count !== 32'd14) begin errors++; $display("FAIL step_count got %0d want 14", step_count); end
  endtask

  task automatic test_int_pending;
    int pulses;
    int_sw = 1'b1;
    tick();
    int_sw = 1'b0;
    repeat (4) tick();
    int_sw = 1'b1;
    tick();
    int_sw = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (int_req !== 1'b0) begin errors++; $display("FAIL int_held cyc %0d got %b want 0", i, int_req); end
    end
    step_btn = 1'b1;
    tick();
    step_btn = 1'b0;
    tick();
    tick();
    checks++; if (cpu_en !== 1'b1 || int_req !== 1'b1) begin errors++; $display("FAIL int_first_en got en=%b req=%b want 1 1", cpu_en, int_req); end
    pulses = (int_req === 1'b1) ? 1 : 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (int_req === 1'b1) pulses++;
    end
    checks++; if (pulses != 1) begin errors++; $display("FAIL int_pulses got %0d want 1", pulses); end
    checks++; if (step_count !== 32'd17) begin errors++; $display("FAIL int_count got %0d want 17", step_count); end
  endtask

`ifdef DEBUG_BREAKPOINT_EN
  task automatic run_to_bp;
    for (int i = 0; i < 40 && pc != 32'h40; i++) tick();
    checks++; if (pc !== 32'h40) begin errors++; $display("FAIL bp_reach pc got %h want 00000040", pc); end
    checks++; if (cpu_en !== 1'b0 || state !== 2'd0) begin errors++; $display("FAIL bp_gate got en=%b st=%0d want en=0 st=0", cpu_en, state); end
    tick();
    checks++; if (state !== 2'd3 || pc !== 32'h40) begin errors++; $display("FAIL bp_break got st=%0d pc=%h want st=3 pc=00000040", state, pc); end
  endtask

  task automatic test_breakpoint;
    pc = 32'd0;
    bp_addr = 32'h40;
    bp_valid = 1'b1;
    core_run = 1'b1;
    debug_en = 1'b0;
    tick();
    run_to_bp();
    step_btn = 1'b1;
    tick();
    step_btn = 1'b0;
    tick();
    checks++; if (cpu_en !== 1'b0 || state !== 2'd3) begin errors++; $display("FAIL bp_wait got en=%b st=%0d want en=0 st=3", cpu_en, state); end
    tick();
    checks++; if (cpu_en !== 1'b1 || pc !== 32'h40) begin errors++; $display("FAIL bp_step got en=%b pc=%h want en=1 pc=00000040", cpu_en, pc); end
    repeat (3) tick();
    checks++; if (state !== 2'd0 || pc !== 32'h4c) begin errors++; $display("FAIL bp_step_end got st=%0d pc=%h want st=0 pc=0000004c", state, pc); end
    pc = 32'd0;
    tick();
    run_to_bp();
    debug_en = 1'b1;
    tick();
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL bp_to_halt got %0d want 1", state); end
    debug_en = 1'b0;
    tick();
    checks++; if (state !== 2'd0 || cpu_en !== 1'b1 || pc !== 32'h40) begin errors++; $display("FAIL bp_skip got st=%0d en=%b pc=%h want st=0 en=1 pc=00000040", state, cpu_en, pc); end
    tick();
    checks++; if (state !== 2'd0 || pc !== 32'h44) begin errors++; $display("FAIL bp_leave got st=%0d pc=%h want st=0 pc=00000044", state, pc); end
    debug_en = 1'b1;
    tick();
    core_run = 1'b0;
    bp_valid = 1'b0;
  endtask
`else
  task automatic test_breakpoint;
    pc = 32'h40;
    bp_addr = 32'h40;
    bp_valid = 1'b1;
    debug_en = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      checks++; if (cpu_en !== 1'b1 || state !== 2'd0) begin errors++; $display("FAIL bp_ignored cyc %0d got en=%b st=%0d want en=1 st=0", i, cpu_en, state); end
      tick();
    end
    debug_en = 1'b1;
    tick();
    bp_valid = 1'b0;
  endtask
`endif

  task automatic test_reset_mid_step;
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL mid_pre_state got %0d want 1", state); end
    step_btn = 1'b1;
    tick();
    step_btn = 1'b0;
    tick();
    tick();
    tick();
    checks++; if (cpu_en !== 1'b1 || state !== 2'd2) begin errors++; $display("FAIL mid_second_cycle got en=%b st=%0d want en=1 st=2", cpu_en, state); end
    rst = 1'b1;
    tick();
    checks++; if (cpu_en !== 1'b0 || state !== 2'd1) begin errors++; $display("FAIL mid_reset got en=%b st=%0d want en=0 st=1", cpu_en, state); end
    checks++; if (step_count !== 32'd0) begin errors++; $display("FAIL mid_reset_count got %0d want 0", step_count); end
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (cpu_en !== 1'b0) begin errors++; $display("FAIL mid_no_resume cyc %0d got %b want 0", i, cpu_en); end
    end
    checks++; if (step_count !== 32'd0) begin errors++; $display("FAIL mid_final_count got %0d want 0", step_count); end
  endtask

  initial begin
    test_reset();
    test_run();
    test_step();
    test_int_pending();
    test_breakpoint();
    test_reset_mid_step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
